mem_byte_hs: RTL and testbench
==============================

# mem_byte_hs

Parametrised byte-lane-masked single-port RAM with valid/ready request and response channels, a 2-entry response buffer for back-pressure, out-of-range address detection and a hardware clear sequencer. It is the successor to the team's simple byte-masked memory: it generalises the lane count to DATAWIDTH/8 and adds flow control, error reporting and bulk zeroing. It sits between a bus/LSU front end and on-chip storage.

## Interface
- DATAWIDTH, 32, word width in bits; must be a multiple of 8
- ADDRESS, 8, address width in bits
- DEPTH, 256, number of words; DEPTH <= 2**ADDRESS
- NBYTES (localparam), DATAWIDTH/8, number of byte lanes
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr_start  in  1  pulse: start zeroing the whole memory
- busy  out  1  clear sequence in progress
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wr  in  1  1 = write, 0 = read
- req_mask  in  NBYTES  per-lane write enable; lane i = bits [8i+7:8i]
- req_addr  in  ADDRESS  word address
- req_wdata  in  DATAWIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  DATAWIDTH  read data
- rsp_err  out  1  response is for an out-of-range address

## Operation
- States: IDLE, CLEAR. Reset -> IDLE.
- req_ready = (state == IDLE) && (rsp_count < 2). It does not depend on req_wr, req_valid or rsp_ready.
- Accepted write with req_addr < DEPTH: for each lane i with req_mask[i] = 1, the lane is updated at the clock edge. Lanes with mask 0 keep their contents. A mask of all zeros is a legal no-op.
- Accepted write with req_addr >= DEPTH: the memory is unchanged and no response is produced. Writes never produce responses.
- Accepted read: {mem[req_addr], err=0} is pushed into the response FIFO at the same edge. If req_addr >= DEPTH, {0, err=1} is pushed instead.
- Response FIFO: 2 entries, in order. rsp_valid = (rsp_count != 0). rsp_data and rsp_err show the head entry.
- A push and a pop in the same cycle leave rsp_count unchanged.
- clr_start is sampled only in IDLE and is ignored in CLEAR.
  - If it arrives together with an accepted request, the request executes in that cycle and CLEAR begins on the next cycle.
- CLEAR: busy = 1 and req_ready = 0. The block writes all-zero words to addresses 0..DEPTH-1, one per cycle, using an internal counter. After writing DEPTH-1 it returns to IDLE.
- Responses already in the FIFO remain deliverable during CLEAR.
- Single port: one access per cycle. A read issued the cycle after a write to the same address returns the new data.

## Timing
- Reset values: busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_count=0, state IDLE.
  - req_ready=1 on the first cycle after rst_n deasserts.
- Memory contents are not reset; they are undefined until written or cleared.
- Read latency: accepted in cycle T -> rsp_valid=1 with data in cycle T+1.
- Throughput: one read per cycle while rsp_ready is held at 1.
- Back-pressure: with rsp_ready=0, two reads are accepted and req_ready drops in the cycle after the second acceptance. It rises again in the cycle after a pop.
- Clear: clr_start in cycle T (IDLE) -> busy=1 from T+1 through T+DEPTH. The state is IDLE and req_ready=1 (if the FIFO is not full) at T+DEPTH+1.
- Reset during CLEAR or with responses pending: the state returns to IDLE and the FIFO empties immediately. Memory is left partially cleared and undefined.

## Test plan
- Write 0xAABBCCDD mask 0xF to addr 5, then write 0x11223344 mask 0x5 to addr 5, then read addr 5 -> rsp_data=0xAA22CC44, rsp_err=0, one cycle after acceptance.
- Read addr 0x10 with DEPTH=16 and ADDRESS=8 -> rsp_data=0, rsp_err=1. Write to the same address, then read addr 0 -> addr 0 unchanged.
- Hold rsp_ready=0 and issue 3 reads to addrs 1,2,3 -> only 2 accepted and req_ready=0. Release rsp_ready -> responses for 1 and 2 in order, then the read of 3 is accepted.
- Back-to-back reads of addrs 0..7 with rsp_ready=1 -> 8 responses on consecutive cycles, req_ready never drops.
- Fill memory, pulse clr_start -> busy high for exactly DEPTH cycles. A req_valid held during that time is not accepted. Afterwards every address reads 0.
- Assert rst_n=0 mid-clear with 2 responses pending -> rsp_valid=0, busy=0 immediately. After release, req_ready=1 and normal write/read works.

Source files
------------

// File: rtl/mem_byte_hs.sv
// mem_byte_hs: byte-lane masked single-port RAM with valid/ready channels,
// a 2-entry response buffer, out-of-range detection and a clear sequencer.
module mem_byte_hs #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRESS   = 8,
    parameter int DEPTH     = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_start,
    output logic                   busy,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [DATAWIDTH/8-1:0] req_mask,
    input  logic [ADDRESS-1:0]     req_addr,
    input  logic [DATAWIDTH-1:0]   req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATAWIDTH-1:0]   rsp_data,
    output logic                   rsp_err
);

    localparam int NBYTES = DATAWIDTH / 8;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDRESS is representable.
    localparam logic [ADDRESS:0] DEPTH_W = (ADDRESS + 1)'(DEPTH);
    localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [AW-1:0]          clr_cnt;
    logic [DATAWIDTH-1:0]   mem [DEPTH];

    logic [DATAWIDTH-1:0]   fifo_data [2];
    logic [1:0]             fifo_err;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             rsp_count;

    logic                   accept;
    logic                   in_range;
    logic                   push;
    logic                   pop;
    logic [AW-1:0]          idx;
    logic [DATAWIDTH-1:0]   rd_word;

    assign in_range = ({1'b0, req_addr} < DEPTH_W);
    assign idx      = req_addr[AW-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    assign accept = req_valid && req_ready;
    assign push   = accept && !req_wr;
    assign pop    = rsp_valid && rsp_ready;

    assign rsp_valid = (rsp_count != 2'd0);
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_err   = fifo_err[rd_ptr];

    // State register; reset always lands in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; clr_start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = (rsp_count != 2'd2);
                if (clr_start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == LAST) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // Clear address counter, parked at zero outside CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
        end else begin
            clr_cnt <= '0;
        end
    end

    // Storage: one access per cycle, clear has the port while busy.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && req_wr && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (req_mask[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Two-entry in-order response buffer; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
            fifo_err  <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            rsp_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rd_word;
                fifo_err[wr_ptr]  <= !in_range;
                wr_ptr            <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   rsp_count <= rsp_count + 2'd1;
                2'b01:   rsp_count <= rsp_count - 2'd1;
                default: rsp_count <= rsp_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_hs.sv
// tb_mem_byte_hs: scoreboard bench for mem_byte_hs with DEPTH=16.
// Directed requests push expected responses; a monitor pops and compares.
module tb_mem_byte_hs;

    localparam int DW = 32;
    localparam int AD = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start;
    logic          busy;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [3:0]    req_mask;
    logic [AD-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks   = 0;
    int   errors   = 0;
    int   pops     = 0;
    int   stalls   = 0;
    int   busy_cyc = 0;
    int   busy_rdy = 0;

    always #5 clk = ~clk;

    mem_byte_hs #(
        .DATAWIDTH(DW),
        .ADDRESS  (AD),
        .DEPTH    (DP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_start(clr_start),
        .busy     (busy),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr   (req_wr),
        .req_mask (req_mask),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the scoreboard whenever a response is consumed.
    always @(negedge clk) begin
        if (rst_n && busy) begin
            busy_cyc++;
            if (req_ready) busy_rdy++;
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %h err %b, none expected",
                         rsp_data, rsp_err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic issue(input logic wr, input logic [3:0] m,
                         input logic [AD-1:0] a, input logic [31:0] d,
                         input exp_t ex);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_mask  = m;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        stalls += n;
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr %h: req_ready=0 required 1", a);
        end else if (!wr) begin
            exp_q.push_back(ex);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [AD-1:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        issue(1'b1, m, a, d, exp_t'(33'd0));
    endtask

    task automatic rd(input logic [AD-1:0] a, input logic [31:0] d,
                      input logic er);
        issue(1'b0, 4'h0, a, 32'h0, exp_t'({er, d}));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int s0;
        int b0;
        rst_n     = 1'b0;
        clr_start = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_mask  = 4'h0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(req_ready), 32'd1);
        tick(1);

        // Lane masking and read latency
        wr(8'd5, 32'hAABBCCDD, 4'hF);
        wr(8'd5, 32'h11223344, 4'h5);
        rd(8'd5, 32'hAA22CC44, 1'b0);
        @(negedge clk);
        check("latency_valid", 32'(rsp_valid), 32'd1);
        tick(1);

        // Out-of-range read and write
        wr(8'd0, 32'h12345678, 4'hF);
        rd(8'h10, 32'h0, 1'b1);
        wr(8'h10, 32'hDEADBEEF, 4'hF);
        rd(8'd0, 32'h12345678, 1'b0);
        tick(2);

        // Back-pressure
        wr(8'd1, 32'h01010101, 4'hF);
        wr(8'd2, 32'h02020202, 4'hF);
        wr(8'd3, 32'h03030303, 4'hF);
        rsp_ready = 1'b0;
        rd(8'd1, 32'h01010101, 1'b0);
        rd(8'd2, 32'h02020202, 1'b0);
        @(negedge clk);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'd3;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold", 32'(req_ready), 32'd0);
        end
        tick(1);
        rsp_ready = 1'b1;
        rd(8'd3, 32'h03030303, 1'b0);
        tick(3);

        // Fill memory, then back-to-back reads
        for (int a = 0; a < DP; a++) begin
            wr(AD'(a), 32'h5A000000 | 32'(a), 4'hF);
        end
        p0 = pops;
        s0 = stalls;
        for (int a = 0; a < 8; a++) begin
            rd(AD'(a), 32'h5A000000 | 32'(a), 1'b0);
        end
        tick(2);
        check("b2b_count", 32'(pops - p0), 32'd8);
        check("b2b_stalls", 32'(stalls - s0), 32'd0);

        // Clear with a read held pending
        b0 = busy_cyc;
        clr_start = 1'b1;
        tick(1);
        clr_start = 1'b0;
        rd(8'd3, 32'h0, 1'b0);
        tick(2);
        check("clr_busy_cycles", 32'(busy_cyc - b0), 32'(DP));
        check("clr_no_ready", 32'(busy_rdy), 32'd0);
        for (int a = 0; a < DP; a++) begin
            rd(AD'(a), 32'h0, 1'b0);
        end
        tick(3);

        // Reset mid-clear with two responses pending
        rsp_ready = 1'b0;
        rd(8'd1, 32'h0, 1'b0);
        rd(8'd2, 32'h0, 1'b0);
        clr_start = 1'b1;
        tick(1);
        clr_start = 1'b0;
        tick(3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", 32'(req_ready), 32'd1);
        tick(1);
        wr(8'd9, 32'hCAFEF00D, 4'hF);
        rd(8'd9, 32'hCAFEF00D, 1'b0);
        wr(8'd9, 32'h0000AB00, 4'h2);
        rd(8'd9, 32'hCAFEAB0D, 1'b0);
        tick(3);

        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
